imem_port_arbiter: RTL and testbench

- Shares the single instruction SRAM read/write port between the fetch stage and the program loader/debug port.
- Fetch issues one read per cycle. The loader issues reads, writes and locked bursts for image download.
- Arbitration is round-robin, with a bounded-hold lock so fetch is never starved.
- Routes 1-cycle-latency read data back to the owning requester and exports a fetch stall counter.

---
 rtl/imem_arb_pkg.sv | 25 ++
 rtl/imem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_imem_port_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_arb_pkg.sv
// -----------------------------------------------------------------------------
// imem_arb_pkg
// Shared types and constants for the instruction-memory port arbiter.
//   arb_state_e : ARB (round-robin) / LOCKED (loader owns the port)
//   requester_e : identifies which requester last owned the SRAM port
// -----------------------------------------------------------------------------
package imem_arb_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_LDR   = 1'b1
    } requester_e;

    // Default bound on consecutive locked loader grants before fetch gets a slot.
    localparam int DEFAULT_MAX_HOLD = 8;

    // Hold counter width; covers the full 1..255 range of MAX_HOLD.
    localparam int HOLD_W = 8;

endpackage

// File: rtl/imem_port_arbiter.sv
// -----------------------------------------------------------------------------
// imem_port_arbiter
// Shares the single instruction SRAM port between the fetch stage and the
// program loader / debug port. Round-robin arbitration, plus a loader lock for
// image-download bursts that is bounded so fetch still gets a slot every
// MAX_HOLD loader grants. Read data returns one cycle after the grant and is
// tagged back to the requester that owned the access.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   fetch_req/addr             fetch read request
//   fetch_gnt                  fetch owns the port this cycle (combinational)
//   fetch_rvalid/rdata         fetch read return
//   ldr_req/we/addr/wdata/lock loader request, write, data, burst lock
//   ldr_gnt                    loader owns the port this cycle (combinational)
//   ldr_rvalid/rdata           loader read return (never for writes)
//   mem_*                      SRAM port
//   fetch_stall_count          saturating count of cycles fetch was refused
// -----------------------------------------------------------------------------
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MAX_HOLD  = DEFAULT_MAX_HOLD,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fetch_req,
    input  logic [WIDTH-1:0]     fetch_addr,
    output logic                 fetch_gnt,
    output logic                 fetch_rvalid,
    output logic [WIDTH-1:0]     fetch_rdata,
    input  logic                 ldr_req,
    input  logic                 ldr_we,
    input  logic [WIDTH-1:0]     ldr_addr,
    input  logic [WIDTH-1:0]     ldr_wdata,
    input  logic                 ldr_lock,
    output logic                 ldr_gnt,
    output logic                 ldr_rvalid,
    output logic [WIDTH-1:0]     ldr_rdata,
    output logic                 mem_enable,
    output logic                 mem_we,
    output logic [WIDTH-1:0]     mem_address,
    output logic [WIDTH-1:0]     mem_wdata,
    input  logic [WIDTH-1:0]     mem_rdata,
    output logic [CNT_WIDTH-1:0] fetch_stall_count
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    arb_state_e           state_q, state_d;
    requester_e           last_grant_q, last_grant_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic                 fetch_rvalid_q, ldr_rvalid_q;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    // Grant decode. Both grants are held low while reset is asserted.
    always_comb begin
        fetch_gnt = 1'b0;
        ldr_gnt   = 1'b0;
        if (rst_n) begin
            case (state_q)
                ARB: begin
                    if (fetch_req && ldr_req) begin
                        // Tie: the requester that did not win last time goes.
                        if (last_grant_q == REQ_LDR) fetch_gnt = 1'b1;
                        else                         ldr_gnt   = 1'b1;
                    end else begin
                        fetch_gnt = fetch_req;
                        ldr_gnt   = ldr_req;
                    end
                end
                LOCKED: begin
                    // Starvation guard: a full hold window hands one slot to fetch.
                    if (hold_cnt_q == HOLD_MAX && fetch_req) fetch_gnt = 1'b1;
                    else                                     ldr_gnt   = ldr_req;
                end
                default: ;
            endcase
        end
    end

    // SRAM port mux.
    assign mem_enable  = fetch_gnt | ldr_gnt;
    assign mem_we      = ldr_gnt & ldr_we;
    assign mem_address = ldr_gnt ? ldr_addr : (fetch_gnt ? fetch_addr : '0);
    assign mem_wdata   = ldr_gnt ? ldr_wdata : '0;

    // Next-state: round-robin pointer, lock state and hold counter.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        hold_cnt_d   = hold_cnt_q;
        if (fetch_gnt) last_grant_d = REQ_FETCH;
        if (ldr_gnt)   last_grant_d = REQ_LDR;
        case (state_q)
            ARB: begin
                // Lock only takes effect if the loader actually won this cycle.
                if (ldr_gnt && ldr_lock) begin
                    state_d    = LOCKED;
                    hold_cnt_d = HOLD_W'(1);
                end
            end
            LOCKED: begin
                if (ldr_gnt && hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                if (fetch_gnt)                         hold_cnt_d = '0;
                if (!ldr_lock || !ldr_req) begin
                    state_d      = ARB;
                    hold_cnt_d   = '0;
                    last_grant_d = REQ_LDR;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (fetch_req && !fetch_gnt && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ARB;
            last_grant_q   <= REQ_LDR;
            hold_cnt_q     <= '0;
            fetch_rvalid_q <= 1'b0;
            ldr_rvalid_q   <= 1'b0;
            stall_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            hold_cnt_q     <= hold_cnt_d;
            fetch_rvalid_q <= fetch_gnt;
            ldr_rvalid_q   <= ldr_gnt & ~ldr_we;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    // Read data is shared and unmasked; the rvalid tags say who owns it.
    assign fetch_rvalid      = fetch_rvalid_q;
    assign ldr_rvalid        = ldr_rvalid_q;
    assign fetch_rdata       = mem_rdata;
    assign ldr_rdata         = mem_rdata;
    assign fetch_stall_count = stall_cnt_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_port_arbiter
// Randomised and directed stimulus against a behavioural arbitration model.
// The driver computes each cycle's expected port behaviour and queues it; a
// negedge monitor pops and compares. Read data expectations come from a
// reference memory image kept separately from the SRAM model the DUT drives.
// -----------------------------------------------------------------------------
module tb_imem_port_arbiter;

    localparam int W     = 32;
    localparam int MAXH  = 4;
    localparam int CNTW  = 4;
    localparam int SMAX  = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            fetch_req = 1'b0;
    logic [W-1:0]    fetch_addr = '0;
    logic            fetch_gnt, fetch_rvalid;
    logic [W-1:0]    fetch_rdata;
    logic            ldr_req = 1'b0, ldr_we = 1'b0, ldr_lock = 1'b0;
    logic [W-1:0]    ldr_addr = '0, ldr_wdata = '0;
    logic            ldr_gnt, ldr_rvalid;
    logic [W-1:0]    ldr_rdata;
    logic            mem_enable, mem_we;
    logic [W-1:0]    mem_address, mem_wdata;
    logic [W-1:0]    mem_rdata = '0;
    logic [CNTW-1:0] fetch_stall_count;

    imem_port_arbiter #(.WIDTH(W), .MAX_HOLD(MAXH), .CNT_WIDTH(CNTW)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_lock(ldr_lock), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
        .mem_enable(mem_enable), .mem_we(mem_we), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .fetch_stall_count(fetch_stall_count)
    );

    always #5 clk = ~clk;

    // SRAM model driven purely by the DUT's memory port.
    logic [W-1:0] sram [64];
    always @(posedge clk) begin
        if (mem_enable) begin
            if (mem_we) sram[mem_address[7:2]] <= mem_wdata;
            else        mem_rdata <= sram[mem_address[7:2]];
        end
    end

    typedef struct {
        logic          fg, lg, en, we, frv, lrv;
        logic [W-1:0]  addr, wdata;
        logic [CNTW-1:0] stall;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] fdata_q[$];
    logic [W-1:0] ldata_q[$];
    logic [W-1:0] ref_mem [64];

    int tests = 0;
    int fails = 0;

    // Reference model state (reset values).
    bit m_locked   = 1'b0;
    int m_hold     = 0;
    bit m_last_ldr = 1'b1;
    int m_stall    = 0;
    bit m_frv      = 1'b0;
    bit m_lrv      = 1'b0;

    function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    // One bus cycle: apply inputs, predict, advance the model.
    task automatic cyc(input bit rst, input bit f, input int fa, input bit l,
                       input bit we, input int la, input logic [W-1:0] wd, input bit lk);
        exp_t e;
        int   w;   // 0 = no grant, 1 = fetch, 2 = loader
        @(posedge clk);
        #1;
        rst_n = !rst; fetch_req = f; fetch_addr = W'(fa);
        ldr_req = l; ldr_we = we; ldr_addr = W'(la); ldr_wdata = wd; ldr_lock = lk;
        w = 0;
        if (!rst) begin
            if (!m_locked) begin
                if (f && l) w = m_last_ldr ? 1 : 2;
                else if (f) w = 1;
                else if (l) w = 2;
            end else begin
                if (m_hold == MAXH && f) w = 1;
                else if (l)              w = 2;
            end
        end
        e.fg = (w == 1); e.lg = (w == 2); e.en = (w != 0); e.we = (w == 2) && we;
        e.addr  = (w == 1) ? W'(fa) : (w == 2) ? W'(la) : '0;
        e.wdata = wd;
        e.frv = m_frv; e.lrv = m_lrv; e.stall = CNTW'(m_stall);
        exp_q.push_back(e);
        if (w == 1) fdata_q.push_back(ref_mem[(fa >> 2) & 63]);
        if (w == 2) begin
            if (we) ref_mem[(la >> 2) & 63] = wd;
            else    ldata_q.push_back(ref_mem[(la >> 2) & 63]);
        end
        if (rst) begin
            m_locked = 0; m_hold = 0; m_last_ldr = 1; m_stall = 0; m_frv = 0; m_lrv = 0;
        end else begin
            if (f && w != 1 && m_stall < SMAX) m_stall++;
            m_frv = (w == 1);
            m_lrv = (w == 2) && !we;
            if (!m_locked) begin
                if (w != 0) m_last_ldr = (w == 2);
                if (w == 2 && lk) begin m_locked = 1; m_hold = 1; end
            end else begin
                if (w == 2) begin m_last_ldr = 1; if (m_hold < MAXH) m_hold++; end
                if (w == 1) begin m_last_ldr = 0; m_hold = 0; end
                if (!lk || !l) begin m_locked = 0; m_hold = 0; m_last_ldr = 1; end
            end
        end
        $display("[TB] cyc rst=%0d f=%0d l=%0d we=%0d lk=%0d -> exp grant=%0d", rst, f, l, we, lk, w);
    endtask

    // Monitor: compare the DUT against the queued expectation for this cycle.
    exp_t         me;
    logic [W-1:0] md;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            chk("fetch_gnt", W'(fetch_gnt), W'(me.fg));
            chk("ldr_gnt", W'(ldr_gnt), W'(me.lg));
            chk("mem_enable", W'(mem_enable), W'(me.en));
            chk("mem_we", W'(mem_we), W'(me.we));
            if (me.en) chk("mem_address", mem_address, me.addr);
            if (me.lg) chk("mem_wdata", mem_wdata, me.wdata);
            chk("fetch_rvalid", W'(fetch_rvalid), W'(me.frv));
            chk("ldr_rvalid", W'(ldr_rvalid), W'(me.lrv));
            chk("fetch_stall_count", W'(fetch_stall_count), W'(me.stall));
            if (me.frv && fdata_q.size() > 0) begin
                md = fdata_q.pop_front();
                chk("fetch_rdata", fetch_rdata, md);
            end
            if (me.lrv && ldata_q.size() > 0) begin
                md = ldata_q.pop_front();
                chk("ldr_rdata", ldr_rdata, md);
            end
        end
    end

    function automatic int ra();
        return int'($urandom_range(0, 63)) * 4;
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) begin
            sram[i]    = W'(i) * 32'h01F3_0A17 + 32'h0000_1234;
            ref_mem[i] = W'(i) * 32'h01F3_0A17 + 32'h0000_1234;
        end

        repeat (2) cyc(1, 0, 0, 0, 0, 0, '0, 0);

        // Fetch streaming alone.
        for (int i = 0; i < 6; i++) cyc(0, 1, i * 4, 0, 0, 0, '0, 0);

        // Both requesting after reset: alternation starting with fetch.
        cyc(1, 0, 0, 0, 0, 0, '0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, ra(), 1, 0, ra(), $urandom, 0);

        // Loader write then fetch read-back of the same word.
        cyc(0, 0, 0, 1, 1, 'h40, 32'hDEAD_BEEF, 0);
        cyc(0, 1, 'h40, 0, 0, 0, '0, 0);
        cyc(0, 0, 0, 0, 0, 0, '0, 0);

        // Locked burst with fetch pressure; fetch owns the last slot so loader wins the tie.
        cyc(0, 1, ra(), 0, 0, 0, '0, 0);
        for (int i = 0; i < 12; i++) cyc(0, 1, ra(), 1, 0, ra(), $urandom, 1);
        for (int i = 0; i < 3; i++)  cyc(0, 1, ra(), 1, 0, ra(), $urandom, 0);

        // Reset in the middle of a locked read burst.
        for (int i = 0; i < 3; i++) cyc(0, 1, ra(), 1, 0, ra(), $urandom, 1);
        cyc(1, 1, ra(), 1, 0, ra(), $urandom, 1);
        cyc(0, 1, ra(), 1, 0, ra(), $urandom, 0);
        cyc(0, 0, 0, 0, 0, 0, '0, 0);

        // Long locked burst drives the stall counter into saturation.
        for (int i = 0; i < 25; i++) cyc(0, 1, ra(), 1, 1'($urandom), ra(), $urandom, 1);
        cyc(0, 0, 0, 0, 0, 0, '0, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 500; i++)
            cyc(($urandom % 60) == 0, ($urandom % 4) != 0, ra(), ($urandom % 3) != 0,
                1'($urandom), ra(), $urandom, ($urandom % 4) != 0);

        cyc(0, 0, 0, 0, 0, 0, '0, 0);
        cyc(0, 0, 0, 0, 0, 0, '0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("fetch_read_drain", W'(fdata_q.size()), '0);
        chk("ldr_read_drain", W'(ldata_q.size()), '0);
        chk("expect_drain", W'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
